// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven two-operand calculator control FSM
module calc_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  output logic [4:0]  num000,
  output logic [4:0]  num001,
  output logic [4:0]  num011,
  output logic [4:0]  num100,
  output logic [2:0]  num_state,
  output logic [4:0]  arithmetic,
  output logic        enable,
  input  logic [13:0] total,
  output logic [13:0] result,
  output logic        result_valid,
  output logic        negative,
  output logic        div_error
);
  typedef enum logic [2:0] {
    ENT_A = 3'b000,
    ENT_B = 3'b010,
    CALC  = 3'b011,
    DONE  = 3'b100,
    ERR   = 3'b101
  } state_t;
  state_t     state;
  logic [1:0] a_cnt, b_cnt;
  logic       is_digit, is_op, is_eq, is_clr;
  logic [6:0] a_val, b_val;
  assign is_digit  = key_valid && key_code < 5'd10;
  assign is_clr    = key_valid && key_code == 5'd10;
  assign is_op     = key_valid && key_code >= 5'd11 && key_code <= 5'd14;
  assign is_eq     = key_valid && key_code == 5'd15;
  assign a_val     = 7'(num000) * 7'd10 + 7'(num001);
  assign b_val     = 7'(num011) * 7'd10 + 7'(num100);
  assign num_state = state;
  // enable is the only combinational output; held low while reset is asserted
  assign enable    = reset_n && state == CALC;
  // sequencer: operand entry, operator latch, one-cycle compute and result capture
  always_ff @(posedge clk) begin
    if (!reset_n || is_clr) begin
      state        <= ENT_A;
      num000       <= '0;
      num001       <= '0;
      num011       <= '0;
      num100       <= '0;
      arithmetic   <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      negative     <= 1'b0;
      div_error    <= 1'b0;
      a_cnt        <= '0;
      b_cnt        <= '0;
    end else begin
      case (state)
        ENT_A:
          if (is_digit) begin
            if (a_cnt != 2'd2) begin
              num000 <= num001;
              num001 <= key_code;
              a_cnt  <= a_cnt + 2'd1;
            end
          end else if (is_op) begin
            arithmetic <= key_code;
            state      <= ENT_B;
          end
        ENT_B:
          if (is_digit) begin
            if (b_cnt != 2'd2) begin
              num011 <= num100;
              num100 <= key_code;
              b_cnt  <= b_cnt + 2'd1;
            end
          end else if (is_op) begin
            if (b_cnt == 2'd0) arithmetic <= key_code;
          end else if (is_eq && b_cnt != 2'd0) begin
            if (arithmetic == 5'd14 && b_val == 7'd0) begin
              state     <= ERR;
              div_error <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        CALC: begin
          result       <= total;
          result_valid <= 1'b1;
          negative     <= arithmetic == 5'd12 && a_val < b_val;
          state        <= DONE;
        end
        DONE:
          if (is_digit) begin
            num000       <= '0;
            num001       <= key_code;
            num011       <= '0;
            num100       <= '0;
            arithmetic   <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            negative     <= 1'b0;
            a_cnt        <= 2'd1;
            b_cnt        <= 2'd0;
            state        <= ENT_A;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed and randomized checks of calc_sequencer against a calculator model
module tb_calc_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [4:0]  key_code = '0;
  logic [4:0]  num000, num001, num011, num100, arithmetic;
  logic [2:0]  num_state;
  logic        enable, result_valid, negative, div_error;
  logic [13:0] total, result;
  logic [45:0] dut_vec;
  int tests = 0;
  int fails = 0;
  int m_phase, m_a, m_na, m_b, m_nb, m_op;
  logic [13:0] m_res;
  bit m_rv, m_neg, m_err;

  calc_sequencer dut (
    .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_code(key_code),
    .num000(num000), .num001(num001), .num011(num011), .num100(num100),
    .num_state(num_state), .arithmetic(arithmetic), .enable(enable), .total(total),
    .result(result), .result_valid(result_valid), .negative(negative), .div_error(div_error)
  );

  always #5 clk = ~clk;

  // stand-in for the external arithmetic datapath
  always_comb begin
    int da, db;
    da = int'(num000) * 10 + int'(num001);
    db = int'(num011) * 10 + int'(num100);
    total = '0;
    if (arithmetic == 5'd11) total = 14'(da + db);
    if (arithmetic == 5'd12) total = 14'(da - db);
    if (arithmetic == 5'd13) total = 14'(da * db);
    if (arithmetic == 5'd14 && db != 0) total = 14'(da / db);
  end

  assign dut_vec = {num_state, num000, num001, num011, num100, arithmetic,
                    result, result_valid, negative, div_error, enable};

  function automatic void model_clear();
    m_phase = 0; m_a = 0; m_na = 0; m_b = 0; m_nb = 0; m_op = 0;
    m_res = '0; m_rv = 0; m_neg = 0; m_err = 0;
  endfunction

  function automatic void model_edge(bit rn, bit kv, int kc);
    bit dig, op, eq;
    dig = kv && kc < 10;
    op  = kv && kc >= 11 && kc <= 14;
    eq  = kv && kc == 15;
    if (!rn || (kv && kc == 10)) model_clear();
    else if (m_phase == 0) begin
      if (dig && m_na < 2) begin m_a = (m_a % 10) * 10 + kc; m_na++; end
      else if (op) begin m_op = kc; m_phase = 2; end
    end else if (m_phase == 2) begin
      if (dig && m_nb < 2) begin m_b = (m_b % 10) * 10 + kc; m_nb++; end
      else if (op && m_nb == 0) m_op = kc;
      else if (eq && m_nb > 0) begin
        if (m_op == 14 && m_b == 0) begin m_phase = 5; m_err = 1; end
        else m_phase = 3;
      end
    end else if (m_phase == 3) begin
      case (m_op)
        11: m_res = 14'(m_a + m_b);
        12: m_res = 14'(m_a - m_b);
        13: m_res = 14'(m_a * m_b);
        default: m_res = 14'(m_a / m_b);
      endcase
      m_neg = m_op == 12 && m_a < m_b;
      m_rv = 1;
      m_phase = 4;
    end else if (m_phase == 4 && dig) begin
      model_clear();
      m_a = kc; m_na = 1;
    end
  endfunction

  function automatic logic [45:0] exp_vec();
    return {3'(m_phase), 5'(m_a / 10), 5'(m_a % 10), 5'(m_b / 10), 5'(m_b % 10), 5'(m_op),
            m_res, m_rv, m_neg, m_err, m_phase == 3};
  endfunction

  task automatic cycle(input bit rn, input bit kv, input int kc);
    reset_n = rn; key_valid = kv; key_code = 5'(kc);
    @(posedge clk);
    model_edge(rn, kv, kc);
    @(negedge clk);
    reset_n = 1'b1; key_valid = 1'b0;
  endtask

  task automatic press(input int kc);
    cycle(1'b1, 1'b1, kc);
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b1, 5);
    cycle(1'b0, 1'b1, 11);
    tests++;
    if (dut_vec !== 46'd0) begin fails++; $display("FAIL reset_values: got %h expected 0", dut_vec); end
    tests++;
    if (dut_vec !== exp_vec()) begin fails++; $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_add();
    press(10); press(1); press(2); press(11); press(3); press(4); press(15);
    tests++;
    if (enable !== 1'b1 || num_state !== 3'b011) begin fails++; $display("FAIL add_calc: got en=%b st=%b expected en=1 st=011", enable, num_state); end
    cycle(1'b1, 1'b0, 0);
    tests++;
    if (result !== 14'd46 || result_valid !== 1'b1 || num_state !== 3'b100 || enable !== 1'b0) begin
      fails++; $display("FAIL add_done: got res=%0d rv=%b st=%b en=%b expected 46 1 100 0", result, result_valid, num_state, enable);
    end
    tests++;
    if (dut_vec !== exp_vec()) begin fails++; $display("FAIL add_model: got %h expected %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_mul_then_digit();
    press(10); press(0); press(7); press(13); press(1); press(2); press(15); cycle(1'b1, 1'b0, 0);
    tests++;
    if (result !== 14'd84 || negative !== 1'b0 || result_valid !== 1'b1) begin fails++; $display("FAIL mul_result: got res=%0d neg=%b rv=%b expected 84 0 1", result, negative, result_valid); end
    press(5);
    tests++;
    if (num_state !== 3'b000 || num001 !== 5'd5 || num000 !== 5'd0 || result_valid !== 1'b0 || result !== 14'd0) begin
      fails++; $display("FAIL done_digit: got st=%b a=%0d%0d rv=%b res=%0d expected 000 05 0 0", num_state, num000, num001, result_valid, result);
    end
    tests++;
    if (dut_vec !== exp_vec()) begin fails++; $display("FAIL done_digit_model: got %h expected %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_sub_negative();
    press(10); press(3); press(12); press(9); press(15); cycle(1'b1, 1'b0, 0);
    tests++;
    if (negative !== 1'b1 || result !== 14'h3FFA) begin fails++; $display("FAIL sub_negative: got neg=%b res=%h expected 1 3ffa", negative, result); end
    press(11); press(15);
    tests++;
    if (dut_vec !== exp_vec() || num_state !== 3'b100) begin fails++; $display("FAIL done_ignores_ops: got %h expected %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_div_error();
    bit saw_en;
    press(10); press(5); press(14);
    saw_en = enable;
    press(0);
    saw_en |= enable;
    press(15);
    saw_en |= enable;
    tests++;
    if (num_state !== 3'b101 || div_error !== 1'b1) begin fails++; $display("FAIL div_error: got st=%b de=%b expected 101 1", num_state, div_error); end
    press(3); press(15);
    saw_en |= enable;
    tests++;
    if (saw_en !== 1'b0 || num_state !== 3'b101) begin fails++; $display("FAIL err_hold: got en_seen=%b st=%b expected 0 101", saw_en, num_state); end
    press(10);
    tests++;
    if (dut_vec !== 46'd0) begin fails++; $display("FAIL err_clear: got %h expected 0", dut_vec); end
  endtask

  task automatic test_digit_limit();
    press(10); press(1); press(2); press(3);
    tests++;
    if (num000 !== 5'd1 || num001 !== 5'd2) begin fails++; $display("FAIL digit_limit: got %0d%0d expected 12", num000, num001); end
    press(15);
    tests++;
    if (num_state !== 3'b000) begin fails++; $display("FAIL eq_in_a: got st=%b expected 000", num_state); end
    press(11); press(12); press(15);
    tests++;
    if (arithmetic !== 5'd12 || num_state !== 3'b010) begin fails++; $display("FAIL op_replace: got op=%0d st=%b expected 12 010", arithmetic, num_state); end
    press(4); press(13); press(15); cycle(1'b1, 1'b0, 0);
    tests++;
    if (arithmetic !== 5'd12 || result !== 14'd8 || negative !== 1'b0) begin fails++; $display("FAIL op_locked: got op=%0d res=%0d neg=%b expected 12 8 0", arithmetic, result, negative); end
  endtask

  task automatic test_reset_in_calc();
    press(10); press(2); press(13); press(3); press(15);
    tests++;
    if (enable !== 1'b1) begin fails++; $display("FAIL calc_entry: got en=%b expected 1", enable); end
    cycle(1'b0, 1'b0, 0);
    tests++;
    if (num_state !== 3'b000 || result !== 14'd0 || result_valid !== 1'b0 || arithmetic !== 5'd0 || enable !== 1'b0) begin
      fails++; $display("FAIL reset_in_calc: got st=%b res=%0d rv=%b op=%0d en=%b expected 000 0 0 0 0", num_state, result, result_valid, arithmetic, enable);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      int r, kc;
      bit rn, kv;
      r  = $urandom_range(0, 99);
      kc = r < 50 ? $urandom_range(0, 9) : r < 70 ? $urandom_range(11, 14) : r < 86 ? 15 : r < 89 ? 10 : $urandom_range(16, 31);
      kv = $urandom_range(0, 3) != 0;
      rn = $urandom_range(0, 59) != 0;
      cycle(rn, kv, kc);
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL random_%0d: got %h expected %h", i, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_add();
    test_mul_then_digit();
    test_sub_negative();
    test_div_error();
    test_digit_limit();
    test_reset_in_calc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
